// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter, the RAM and the LSU.
package ram_arbiter_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 14;
  localparam int unsigned DATA_W_DEFAULT = 32;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  typedef enum logic {
    StOpen,
    StLock1
  } arb_state_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// One requester port of the data-RAM arbiter; master = requester, slave = arbiter.
interface ram_arbiter_if #(
  parameter int unsigned ADDR_W = ram_arbiter_pkg::ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = ram_arbiter_pkg::DATA_W_DEFAULT
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              lock;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata, lock,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, lock,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/rr_pick.sv
// Two-input round-robin chooser; m0 can be masked out or forced to win a tie.
module rr_pick
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       force_m0,
  input  logic       mask_m0,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (mask_m0) begin
      gnt = {req[1], 1'b0};
    end else if (req == 2'b11) begin
      gnt = (force_m0 || (last_gnt == REQ_LDR)) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates CPU (m0) and loader (m1) onto the single-port data RAM, with
// a bounded m1 lock so the CPU cannot be starved.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W   = DATA_W_DEFAULT,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  ram_arbiter_if.slave      m0,
  ram_arbiter_if.slave      m1,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              cpu_stall
);

  localparam int unsigned CntW = $clog2(LOCK_MAX + 1);

  arb_state_e      state_q;
  logic [CntW-1:0] lock_cnt_q;
  logic            last_gnt_q;
  logic            force_m0_q;
  logic            rd_pend_q;
  logic            rd_owner_q;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       locked;
  logic       timeout;
  logic       mask_m0;
  logic       lock_ok;

  // Grants are combinational, so they are gated while reset is held.
  assign req     = {m1.req, m0.req} & {2{rst}};
  assign locked  = (state_q == StLock1) && m1.lock;
  assign timeout = locked && (lock_cnt_q >= CntW'(LOCK_MAX));
  assign mask_m0 = locked && !timeout;
  // After a forced release the lock is honoured again once m0 has no demand.
  assign lock_ok = !force_m0_q || !m0.req;

  rr_pick u_rr_pick (
    .req      (req),
    .last_gnt (last_gnt_q),
    .force_m0 (force_m0_q | timeout),
    .mask_m0  (mask_m0),
    .gnt      (gnt)
  );

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (gnt[0]) begin
      ram_we    = m0.we;
      ram_addr  = m0.addr;
      ram_wdata = m0.wdata;
    end else if (gnt[1]) begin
      ram_we    = m1.we;
      ram_addr  = m1.addr;
      ram_wdata = m1.wdata;
    end
  end

  assign m0.gnt    = gnt[0];
  assign m1.gnt    = gnt[1];
  assign cpu_stall = req[0] & ~gnt[0];

  assign m0.rvalid = rd_pend_q && (rd_owner_q == REQ_CPU);
  assign m1.rvalid = rd_pend_q && (rd_owner_q == REQ_LDR);
  assign m0.rdata  = m0.rvalid ? ram_rdata : '0;
  assign m1.rdata  = m1.rvalid ? ram_rdata : '0;

  logic unused_m0_lock;
  assign unused_m0_lock = m0.lock;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StOpen;
      lock_cnt_q <= '0;
      last_gnt_q <= REQ_LDR;
      force_m0_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= REQ_CPU;
    end else begin
      rd_pend_q <= (|gnt) && !ram_we;
      if (|gnt) begin
        last_gnt_q <= gnt[1];
        rd_owner_q <= gnt[1];
      end

      if (gnt[0]) begin
        force_m0_q <= 1'b0;
      end else if (timeout) begin
        force_m0_q <= 1'b1;
      end else if ((state_q == StOpen) && !m0.req) begin
        force_m0_q <= 1'b0;
      end

      unique case (state_q)
        StOpen: begin
          if (gnt[1] && m1.lock && lock_ok) begin
            state_q    <= StLock1;
            lock_cnt_q <= CntW'(1);
          end
        end
        StLock1: begin
          if (mask_m0) begin
            if (lock_cnt_q < CntW'(LOCK_MAX)) lock_cnt_q <= lock_cnt_q + 1'b1;
          end else begin
            state_q    <= StOpen;
            lock_cnt_q <= '0;
          end
        end
        default: begin
          state_q    <= StOpen;
          lock_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench: two arbiters (LOCK_MAX 16 and 4) share one directed stimulus.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;

  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a0 ();
  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a1 ();
  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();

  assign a0.req = m0_req;  assign a0.we = m0_we;  assign a0.addr = m0_addr;
  assign a0.wdata = m0_wdata;  assign a0.lock = 1'b0;
  assign b0.req = m0_req;  assign b0.we = m0_we;  assign b0.addr = m0_addr;
  assign b0.wdata = m0_wdata;  assign b0.lock = 1'b0;
  assign a1.req = m1_req;  assign a1.we = m1_we;  assign a1.addr = m1_addr;
  assign a1.wdata = m1_wdata;  assign a1.lock = m1_lock;
  assign b1.req = m1_req;  assign b1.we = m1_we;  assign b1.addr = m1_addr;
  assign b1.wdata = m1_wdata;  assign b1.lock = m1_lock;

  logic          a_we, b_we, a_stall, b_stall;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(16)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .m0        (a0),
    .m1        (a1),
    .ram_we    (a_we),
    .ram_addr  (a_addr),
    .ram_wdata (a_wdata),
    .ram_rdata (a_rdata),
    .cpu_stall (a_stall)
  );

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(4)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .m0        (b0),
    .m1        (b1),
    .ram_we    (b_we),
    .ram_addr  (b_addr),
    .ram_wdata (b_wdata),
    .ram_rdata (b_rdata),
    .cpu_stall (b_stall)
  );

  // RAM models: two fixed words plus a small writable region.
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];

  function automatic logic [DW-1:0] fixed_or(input logic [AW-1:0] ad, input logic [DW-1:0] d);
    if (ad == 14'h010) return 32'hDEADBEEF;
    if (ad == 14'h011) return 32'hCAFEF00D;
    return d;
  endfunction

  always @(posedge clk) begin
    if (a_we) mem_a[a_addr[7:0]] <= a_wdata;
    if (b_we) mem_b[b_addr[7:0]] <= b_wdata;
    a_rdata <= fixed_or(a_addr, mem_a[a_addr[7:0]]);
    b_rdata <= fixed_or(b_addr, mem_b[b_addr[7:0]]);
  end

  typedef struct {
    logic [1:0]    ga, gb;
    logic          stall_a, stall_b;
    logic          we;
    logic [AW-1:0] addr;
  } cyc_t;

  typedef struct {
    logic          owner;
    logic [DW-1:0] data;
  } rd_t;

  cyc_t cyc_q[$];
  rd_t  qa[$];
  rd_t  qb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_rd(input string nm, input logic v0, input logic v1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1, input rd_t e);
    chk({nm, "_valid"}, {v1, v0}, e.owner ? 2'b10 : 2'b01);
    chk({nm, "_data"}, e.owner ? d1 : d0, e.data);
    chk({nm, "_other"}, e.owner ? d0 : d1, '0);
  endtask

  // One cycle of stimulus; its expected response goes to the scoreboard.
  task automatic step(input logic rs,
                      input logic r0, input logic w0, input logic [AW-1:0] ad0,
                      input logic [DW-1:0] wd0,
                      input logic r1, input logic w1, input logic [AW-1:0] ad1,
                      input logic [DW-1:0] wd1, input logic lk,
                      input logic [1:0] ga, input logic [1:0] gb,
                      input logic rd, input logic [DW-1:0] rdat);
    cyc_t c;
    rd_t  e;
    @(posedge clk);
    #1;
    rst = rs;
    m0_req = r0;  m0_we = w0;  m0_addr = ad0;  m0_wdata = wd0;
    m1_req = r1;  m1_we = w1;  m1_addr = ad1;  m1_wdata = wd1;  m1_lock = lk;
    c.ga = ga;
    c.gb = gb;
    c.stall_a = r0 & rs & ~ga[0];
    c.stall_b = r0 & rs & ~gb[0];
    c.we   = ga[0] ? w0 : (ga[1] ? w1 : 1'b0);
    c.addr = ga[0] ? ad0 : (ga[1] ? ad1 : '0);
    cyc_q.push_back(c);
    if (rd) begin
      e.owner = ga[1];
      e.data  = rdat;
      qa.push_back(e);
      qb.push_back(e);
    end
  endtask

  cyc_t mc;
  rd_t  me;

  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      mc = cyc_q.pop_front();
      chk("gnt_a", {a1.gnt, a0.gnt}, mc.ga);
      chk("gnt_b", {b1.gnt, b0.gnt}, mc.gb);
      chk("stall_a", a_stall, mc.stall_a);
      chk("stall_b", b_stall, mc.stall_b);
      chk("ram_we_a", a_we, mc.we);
      chk("ram_addr_a", a_addr, mc.addr);
    end
    if (a0.rvalid || a1.rvalid) begin
      if (qa.size() == 0) chk("spurious_rvalid_a", {a1.rvalid, a0.rvalid}, 2'b00);
      else begin
        me = qa.pop_front();
        chk_rd("rd_a", a0.rvalid, a1.rvalid, a0.rdata, a1.rdata, me);
      end
    end else begin
      chk("rdata_idle_a", {a1.rdata, a0.rdata}, '0);
    end
    if (b0.rvalid || b1.rvalid) begin
      if (qb.size() == 0) chk("spurious_rvalid_b", {b1.rvalid, b0.rvalid}, 2'b00);
      else begin
        me = qb.pop_front();
        chk_rd("rd_b", b0.rvalid, b1.rvalid, b0.rdata, b1.rdata, me);
      end
    end
  end

  localparam logic [DW-1:0] DB = 32'hDEADBEEF;
  localparam logic [DW-1:0] CF = 32'hCAFEF00D;

  initial begin
    rst = 1'b1;
    m0_req = 0;  m0_we = 0;  m0_addr = '0;  m0_wdata = '0;
    m1_req = 0;  m1_we = 0;  m1_addr = '0;  m1_wdata = '0;  m1_lock = 0;
    #1 rst = 1'b0;
    // Reset held with both requesting: nothing granted, no stall.
    step(0, 1, 0, 14'h010, 0, 1, 0, 14'h011, 0, 0, 2'b00, 2'b00, 0, 0);
    step(0, 1, 0, 14'h010, 0, 1, 0, 14'h011, 0, 0, 2'b00, 2'b00, 0, 0);
    // Single reads, then a four-cycle tie alternating m0, m1.
    step(1, 1, 0, 14'h010, 0, 0, 0, 14'h000, 0, 0, 2'b01, 2'b01, 1, DB);
    step(1, 0, 0, 14'h000, 0, 1, 0, 14'h011, 0, 0, 2'b10, 2'b10, 1, CF);
    step(1, 1, 0, 14'h010, 0, 1, 0, 14'h011, 0, 0, 2'b01, 2'b01, 1, DB);
    step(1, 1, 0, 14'h010, 0, 1, 0, 14'h011, 0, 0, 2'b10, 2'b10, 1, CF);
    step(1, 1, 0, 14'h010, 0, 1, 0, 14'h011, 0, 0, 2'b01, 2'b01, 1, DB);
    step(1, 1, 0, 14'h010, 0, 1, 0, 14'h011, 0, 0, 2'b10, 2'b10, 1, CF);
    // m1 write, m0 reads it back the next cycle.
    step(1, 0, 0, 14'h000, 0, 1, 1, 14'h020, 32'h12345678, 0, 2'b10, 2'b10, 0, 0);
    step(1, 1, 0, 14'h020, 0, 0, 0, 14'h000, 0, 0, 2'b01, 2'b01, 1, 32'h12345678);
    step(1, 0, 0, 14'h000, 0, 0, 0, 14'h000, 0, 0, 2'b00, 2'b00, 0, 0);
    // Lock hold for 5 cycles; the LOCK_MAX=4 copy times out on the fifth.
    for (int i = 0; i < 4; i++)
      step(1, 1, 1, 14'h030, 1, 1, 1, 14'h031, 2, 1, 2'b10, 2'b10, 0, 0);
    step(1, 1, 1, 14'h030, 1, 1, 1, 14'h031, 2, 1, 2'b10, 2'b01, 0, 0);
    step(1, 1, 1, 14'h030, 1, 0, 0, 14'h000, 0, 0, 2'b01, 2'b01, 0, 0);
    // Continuous locked m1 against a waiting m0.
    for (int i = 0; i < 4; i++)
      step(1, 1, 1, 14'h030, 3, 1, 1, 14'h031, 4, 1, 2'b10, 2'b10, 0, 0);
    step(1, 1, 1, 14'h030, 3, 1, 1, 14'h031, 4, 1, 2'b10, 2'b01, 0, 0);
    step(1, 1, 1, 14'h030, 3, 1, 1, 14'h031, 4, 1, 2'b10, 2'b10, 0, 0);
    step(1, 0, 0, 14'h000, 0, 0, 0, 14'h000, 0, 0, 2'b00, 2'b00, 0, 0);
    // Reset one cycle after a read grant: the read response must vanish.
    step(1, 1, 0, 14'h010, 0, 0, 0, 14'h000, 0, 0, 2'b01, 2'b01, 0, 0);
    step(0, 1, 0, 14'h010, 0, 1, 0, 14'h011, 0, 1, 2'b00, 2'b00, 0, 0);
    step(0, 1, 0, 14'h010, 0, 1, 0, 14'h011, 0, 1, 2'b00, 2'b00, 0, 0);
    step(1, 1, 0, 14'h010, 0, 1, 0, 14'h011, 0, 0, 2'b01, 2'b01, 1, DB);
    step(1, 0, 0, 14'h000, 0, 0, 0, 14'h000, 0, 0, 2'b00, 2'b00, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("pending_cycles", cyc_q.size(), 0);
    chk("pending_reads_a", qa.size(), 0);
    chk("pending_reads_b", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter for the single-port synchronous data RAM. Requester 0 is the CPU load/store unit; requester 1 is the program loader/debug port. The block sits between both and the RAM: it issues at most one access per cycle, returns read data one cycle later, and raises a stall to the CPU while its access is blocked. Requester 1 may lock the RAM for bursts; a bounded lock timeout protects the CPU from starvation.

## Interface
- ADDR_W, 14, RAM word-address width
- DATA_W, 32, data width
- LOCK_MAX, 16, maximum consecutive locked cycles before forced release (≥1)

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- m0_req / m1_req  in  1  access request; held until granted
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR_W  word address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m1_lock  in  1  keep ownership after this grant
- m0_gnt / m1_gnt  out  1  access issued this cycle (combinational)
- m0_rvalid / m1_rvalid  out  1  read data valid (registered)
- m0_rdata / m1_rdata  out  DATA_W  ram_rdata when own rvalid, else 0
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after the address
- cpu_stall  out  1  m0_req & ~m0_gnt

## Operation
- States: OPEN, LOCK1.
- OPEN, exactly one request: grant it.
- OPEN, both requesting: grant the requester not granted most recently (last_gnt). last_gnt resets to 1, so m0 wins the first tie.
- OPEN, m1 granted with m1_lock=1: next state LOCK1, lock_cnt ← 1.
- LOCK1, m1_lock=1 and lock_cnt<LOCK_MAX:
  - m0 is never granted.
  - m1 is granted if it requests.
  - lock_cnt increments every cycle, whether or not m1 requests.
- LOCK1, m1_lock=0: arbitration is as in OPEN this same cycle; next state OPEN.
- LOCK1, lock_cnt==LOCK_MAX:
  - Forced release; next state OPEN.
  - force_m0 is set, so m0 wins the next tie regardless of last_gnt; force_m0 clears when m0 is granted.
  - m1_lock is ignored until m0 has been granted once, or until the first cycle m0_req=0 in OPEN.
- Grant issues: ram_we = granted we; ram_addr and ram_wdata come from the granted requester.
- No grant: ram_we=0, ram_addr=0, ram_wdata=0.
- Read grant sets rd_pend and rd_owner at the clock edge. Next cycle, that owner's rvalid=1.
- Back-to-back grants are allowed: a new grant can issue in the same cycle as the previous read's rvalid.
- Writes complete at the grant clock edge; no response.

## Timing
- Grant: same cycle as request (combinational from req, state, last_gnt, force_m0).
- Read latency: rvalid exactly 1 cycle after gnt.
- Throughput: 1 access per cycle.
- While rst=0:
  - All gnt, rvalid, ram_we, cpu_stall = 0; rdata = 0.
  - state=OPEN, last_gnt=1, lock_cnt=0, rd_pend=0, force_m0=0.
- Reset asserted mid-read: pending rvalid is dropped and never appears after reset release.
- Reset asserted mid-lock: returns to OPEN.
- Request dropped before grant is legal; no side effect.
- lock_cnt width: clog2(LOCK_MAX+1); saturates, never wraps.
- Simultaneous m1_lock deassert and timeout: treated as deassert; force_m0 is not set.

## Structure
- Shared package holds:
  - the state enum (OPEN, LOCK1);
  - the requester-ID constants REQ_CPU=0, REQ_LDR=1;
  - ADDR_W/DATA_W defaults, shared with the RAM and LSU.
- Sub-module rr_pick: two-input round-robin chooser.
  - Inputs: req[1:0], last_gnt, force_m0, mask_m0.
  - Output: gnt[1:0].
  - Combinational; reused by any later arbiter.
- Registers live in ram_arbiter: state, lock_cnt, last_gnt, force_m0, rd_pend, rd_owner.

## Test plan
- Reset and single read: rst released; m0 reads addr 0x010, RAM holds 0xDEADBEEF.
  - m0_gnt in cycle 0.
  - Cycle 1: m0_rvalid=1, m0_rdata=0xDEADBEEF; m1_rvalid=0.
- Tie, round-robin: both request reads every cycle for 4 cycles.
  - Grants alternate m0, m1, m0, m1.
  - cpu_stall=1 in cycles 1 and 3.
- Write then read back-to-back: m1 writes 0x12345678 to 0x020; next cycle m0 reads 0x020.
  - Cycle 2: m0_rdata=0x12345678.
- Lock hold: m1 grants with m1_lock=1 for 5 cycles while m0_req=1, LOCK_MAX=16.
  - m0_gnt=0 and cpu_stall=1 for all 5 cycles.
  - m1_lock drops in cycle 5 with m1_req=0: m0 granted that same cycle.
- Lock timeout: LOCK_MAX=4; m1 holds lock and requests continuously; m0_req=1.
  - m1 granted 4 locked cycles, then m0 granted in the next cycle.
  - m1_lock ignored until that m0 grant.
- Reset mid-read: read granted in cycle 0, rst=0 asserted in cycle 1.
  - rvalid stays 0 during and after reset.
  - First post-reset tie grants m0.
